// File: rtl/uart_tx.sv
// uart_tx: UART transmitter for the debugger unit.
//
// Sends one byte per frame on `tx`: a start bit, LEN_DATA data bits (LSB
// first) and a stop period of STOP_BIT_COUNT ticks. Timing is paced by the
// shared 16x oversampling tick `s_tick`. A one-entry holding buffer lets the
// host queue the next byte while a frame is on the line, so consecutive
// frames follow each other with no idle gap.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   s_tick    16x baud tick, one-cycle pulse
//   tx_start  write strobe, accepted when tx_ready is high
//   din       byte to send, sampled in the accept cycle only
//   tx        registered serial line, idles high
//   tx_ready  holding buffer empty, so a write is accepted this cycle
//   tx_busy   a frame is on the line
//   tx_done   one-cycle pulse on the cycle the final stop tick is consumed

module uart_tx #(
  parameter int LEN_DATA       = 8,
  parameter int STOP_BIT_COUNT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  // The tick counter has to reach both 15 (bit periods) and the stop length.
  localparam int S_MAX = (STOP_BIT_COUNT > 16) ? STOP_BIT_COUNT : 16;
  localparam int S_W   = $clog2(S_MAX);

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_BIT_COUNT - 1);
  localparam logic [2:0]     N_LAST      = 3'(LEN_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       hb_q, hb_d;
  logic             hv_q, hv_d;
  logic             tx_q, tx_d;

  logic             wr_acc;
  logic             stop_end;

  // A write is only taken when the holding buffer is empty; otherwise it is
  // silently dropped. stop_end marks the tick that finishes the stop period.
  assign wr_acc   = tx_start & ~hv_q;
  assign stop_end = (state_q == STOP) & s_tick & (s_q == S_STOP_LAST);

  // Next-state logic for the frame sequencer, the shift register and the
  // holding buffer. At the end of a stop period a buffered byte (or a byte
  // written in that very cycle) is loaded straight into the shift register
  // so the next start bit follows without an idle gap. The line level is
  // derived from the next state so tx is a clean register output.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    hb_d    = hb_q;
    hv_d    = hv_q;

    case (state_q)
      IDLE: begin
        if (wr_acc) begin
          sh_d    = din;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d  = '0;
            sh_d = sh_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d = '0;
            if (hv_q) begin
              sh_d    = hb_q;
              hv_d    = 1'b0;
              state_d = START;
            end else if (wr_acc) begin
              sh_d    = din;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Writes during a frame park in the holding buffer, except on the stop
    // exit cycle where the byte went straight into the shift register.
    if (wr_acc && (state_q != IDLE) && !stop_end) begin
      hb_d = din;
      hv_d = 1'b1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State register. Reset abandons any frame and drives the line high at
  // once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      hb_q    <= '0;
      hv_q    <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      hb_q    <= hb_d;
      hv_q    <= hv_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ~hv_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = stop_end;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
//
// Two instances share all inputs: one with the default frame (8 data bits,
// 1 stop bit) and one with 7 data bits and a 32-tick stop period. A
// frame-level reference model tracks, per instance, how many ticks of the
// current frame have elapsed and which byte is waiting, and from that
// predicts tx, tx_ready, tx_busy and tx_done every cycle. Directed tables
// and short hand-written sequences cover the corner cases.

module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;

  logic tx0, txReady0, txBusy0, txDone0;
  logic tx1, txReady1, txBusy1, txDone1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tickPeriod = 4;
  int doneCount[2];

  uart_tx #(.LEN_DATA(8), .STOP_BIT_COUNT(16)) dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx0), .tx_ready(txReady0), .tx_busy(txBusy0), .tx_done(txDone0)
  );

  uart_tx #(.LEN_DATA(7), .STOP_BIT_COUNT(32)) dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx1), .tx_ready(txReady1), .tx_busy(txBusy1), .tx_done(txDone1)
  );

  // Free-running 100 MHz style clock; inputs change on the falling edge.
  always #5 clk = ~clk;

  // Reference model of one transmitter. A frame is just a count of elapsed
  // ticks: slot 0 is the start bit, slots 1..len the data bits, everything
  // after that the stop period, and the frame ends on its last tick.
  typedef struct {
    int         len;
    int         stopTicks;
    bit         busy;
    int         el;
    logic [7:0] cur;
    bit         hv;
    logic [7:0] hb;
  } model_t;

  model_t mdl[2];

  function automatic model_t mdlReset(int len, int stopTicks);
    model_t r;
    r.len = len; r.stopTicks = stopTicks;
    r.busy = 1'b0; r.el = 0; r.cur = 8'h00; r.hv = 1'b0; r.hb = 8'h00;
    return r;
  endfunction

  function automatic int frameTicks(model_t m);
    return 16 * (1 + m.len) + m.stopTicks;
  endfunction

  function automatic bit mdlDone(model_t m, bit tick);
    return m.busy && tick && (m.el == frameTicks(m) - 1);
  endfunction

  function automatic bit mdlTx(model_t m);
    int slot;
    if (!m.busy) return 1'b1;
    slot = m.el / 16;
    if (slot == 0) return 1'b0;
    if (slot <= m.len) return m.cur[slot-1];
    return 1'b1;
  endfunction

  function automatic model_t mdlStep(model_t m, bit start, logic [7:0] d, bit tick);
    model_t r = m;
    bit acc = start && !m.hv;
    if (!m.busy) begin
      if (acc) begin
        r.busy = 1'b1; r.el = 0; r.cur = d;
      end
    end else begin
      if (acc && !mdlDone(m, tick)) begin
        r.hb = d; r.hv = 1'b1;
      end
      if (tick) begin
        if (m.el == frameTicks(m) - 1) begin
          r.el = 0;
          if (m.hv) begin
            r.cur = m.hb; r.hv = 1'b0;
          end else if (acc) begin
            r.cur = d;
          end else begin
            r.busy = 1'b0;
          end
        end else begin
          r.el = m.el + 1;
        end
      end
    end
    return r;
  endfunction

  // One comparison of a single-bit DUT output against its expected value.
  task automatic checkOutput(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, actual, expected);
    end
  endtask

  // Integer comparison for counts gathered over a sequence.
  task automatic checkValue(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit tickNow();
    return (cyc % tickPeriod) == 0;
  endfunction

  // Drives one clock cycle of inputs (called on the falling edge), checks
  // every output of both instances against the model just before the
  // rising edge, then advances the model with the same inputs.
  task automatic applyStimulus(input bit start, input logic [7:0] d, input bit tick);
    tx_start = start;
    din      = d;
    s_tick   = tick;
    #3;
    checkOutput("dut0 tx",    tx0,      mdlTx(mdl[0]));
    checkOutput("dut0 ready", txReady0, !mdl[0].hv);
    checkOutput("dut0 busy",  txBusy0,  mdl[0].busy);
    checkOutput("dut0 done",  txDone0,  mdlDone(mdl[0], tick));
    checkOutput("dut1 tx",    tx1,      mdlTx(mdl[1]));
    checkOutput("dut1 ready", txReady1, !mdl[1].hv);
    checkOutput("dut1 busy",  txBusy1,  mdl[1].busy);
    checkOutput("dut1 done",  txDone1,  mdlDone(mdl[1], tick));
    if (txDone0) doneCount[0]++;
    if (txDone1) doneCount[1]++;
    @(posedge clk);
    mdl[0] = mdlStep(mdl[0], start, d, tick);
    mdl[1] = mdlStep(mdl[1], start, d, tick);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, tickNow());
  endtask

  // Runs idle cycles until the model says both transmitters are idle, with
  // a cycle budget so a stuck design still reaches the summary.
  task automatic drain(input int bound);
    int g = 0;
    while ((mdl[0].busy || mdl[1].busy) && g < bound) begin
      idleCycle();
      g++;
    end
    checkOutput("drain dut0 idle", txBusy0, 1'b0);
    checkOutput("drain dut1 idle", txBusy1, 1'b0);
  endtask

  typedef struct {
    bit         start;
    logic [7:0] d;
    bit         tick;
    logic       expTx;
    logic       expReady;
    logic       expBusy;
  } vec_t;

  // Main test sequence.
  initial begin
    vec_t       vecs[6];
    logic       txLog[700];
    logic       expBits[11];
    logic [7:0] byteVal;
    int         guard;
    bit         gap;
    bit         hit;
    bit         t;
    int         tickCnt0, tickCnt1;

    // Start of a back-to-back run from idle: a tick in idle and a tick
    // coincident with the first write are both ignored, a second write is
    // buffered and a third one is dropped.
    vecs[0] = '{start:1'b0, d:8'h00, tick:1'b1, expTx:1'b1, expReady:1'b1, expBusy:1'b0};
    vecs[1] = '{start:1'b1, d:8'hA3, tick:1'b1, expTx:1'b0, expReady:1'b1, expBusy:1'b1};
    vecs[2] = '{start:1'b0, d:8'h00, tick:1'b1, expTx:1'b0, expReady:1'b1, expBusy:1'b1};
    vecs[3] = '{start:1'b1, d:8'h0F, tick:1'b0, expTx:1'b0, expReady:1'b0, expBusy:1'b1};
    vecs[4] = '{start:1'b1, d:8'h77, tick:1'b1, expTx:1'b0, expReady:1'b0, expBusy:1'b1};
    vecs[5] = '{start:1'b0, d:8'h00, tick:1'b0, expTx:1'b0, expReady:1'b0, expBusy:1'b1};

    rst = 1'b1; tx_start = 1'b0; din = 8'h00; s_tick = 1'b0;
    mdl[0] = mdlReset(8, 16);
    mdl[1] = mdlReset(7, 32);
    doneCount[0] = 0; doneCount[1] = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    checkOutput("reset tx",    tx0,      1'b1);
    checkOutput("reset ready", txReady0, 1'b1);
    checkOutput("reset busy",  txBusy0,  1'b0);
    checkOutput("reset done",  txDone0,  1'b0);
    checkOutput("reset tx1",   tx1,      1'b1);
    rst = 1'b0;

    // Table-driven start of the back-to-back scenario.
    $display("[TB] back-to-back with buffered and dropped writes");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].start, vecs[i].d, vecs[i].tick);
      checkOutput($sformatf("vec%0d dut0 tx", i),    tx0,      vecs[i].expTx);
      checkOutput($sformatf("vec%0d dut0 ready", i), txReady0, vecs[i].expReady);
      checkOutput($sformatf("vec%0d dut0 busy", i),  txBusy0,  vecs[i].expBusy);
      checkOutput($sformatf("vec%0d dut1 ready", i), txReady1, vecs[i].expReady);
      checkOutput($sformatf("vec%0d dut1 busy", i),  txBusy1,  vecs[i].expBusy);
    end
    gap = 1'b0;
    guard = 0;
    while (doneCount[0] < 2 && guard < 4000) begin
      idleCycle();
      if (doneCount[0] < 2 && !txBusy0) gap = 1'b1;
      guard++;
    end
    checkValue("b2b dut0 done pulses", doneCount[0], 2);
    checkValue("b2b idle gap", int'(gap), 0);
    drain(4000);
    checkValue("b2b dut0 done pulses after drain", doneCount[0], 2);
    checkValue("b2b dut1 done pulses", doneCount[1], 2);

    // Single byte 0x55 with a tick every 4 clocks: each bit lasts 64 clocks.
    $display("[TB] single byte 0x55");
    tickPeriod = 4;
    doneCount[0] = 0;
    byteVal = 8'h55;
    expBits[0] = 1'b0;
    for (int b = 0; b < 8; b++) expBits[1+b] = byteVal[b];
    expBits[9]  = 1'b1;
    expBits[10] = 1'b1;
    applyStimulus(1'b1, byteVal, tickNow());
    txLog[0] = tx0;
    for (int k = 1; k < 700; k++) begin
      idleCycle();
      txLog[k] = tx0;
    end
    for (int i = 0; i < 11; i++)
      checkOutput($sformatf("0x55 bit slot %0d", i), txLog[32 + 64*i], expBits[i]);
    checkValue("0x55 done pulses", doneCount[0], 1);
    checkOutput("0x55 busy after", txBusy0, 1'b0);
    drain(2000);

    // Frame length in ticks for 0xFF on both parameter sets.
    $display("[TB] frame length with 0xFF");
    tickPeriod = 3;
    tickCnt0 = 0; tickCnt1 = 0;
    applyStimulus(1'b1, 8'hFF, tickNow());
    guard = 0;
    while ((txBusy0 || txBusy1) && guard < 3000) begin
      t = tickNow();
      if (t && txBusy0) tickCnt0++;
      if (t && txBusy1) tickCnt1++;
      applyStimulus(1'b0, 8'h00, t);
      guard++;
    end
    checkValue("0xFF dut0 frame ticks", tickCnt0, 16 * (1 + 8) + 16);
    checkValue("0xFF dut1 frame ticks", tickCnt1, 16 * (1 + 7) + 32);
    drain(100);

    // A write landing exactly on the tx_done cycle with an empty buffer
    // goes straight onto the line.
    $display("[TB] stop-exit bypass");
    tickPeriod = 4;
    hit = 1'b0;
    applyStimulus(1'b1, 8'h3C, tickNow());
    guard = 0;
    while (!hit && guard < 1000) begin
      t = tickNow();
      if (mdlDone(mdl[0], t)) begin
        applyStimulus(1'b1, 8'h81, t);
        checkOutput("bypass tx start", tx0,      1'b0);
        checkOutput("bypass busy",     txBusy0,  1'b1);
        checkOutput("bypass ready",    txReady0, 1'b1);
        hit = 1'b1;
      end else begin
        applyStimulus(1'b0, 8'h00, t);
      end
      guard++;
    end
    checkValue("bypass reached done cycle", int'(hit), 1);
    drain(3000);

    // Asynchronous reset in the middle of the data bits.
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h5A, tickNow());
    repeat (100) idleCycle();
    checkOutput("pre-reset busy", txBusy0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset tx",    tx0,      1'b1);
    checkOutput("async reset ready", txReady0, 1'b1);
    checkOutput("async reset busy",  txBusy0,  1'b0);
    checkOutput("async reset busy1", txBusy1,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    mdl[0] = mdlReset(8, 16);
    mdl[1] = mdlReset(7, 32);
    applyStimulus(1'b1, 8'hC6, tickNow());
    drain(3000);

    // Random bytes with random spacing; the model checks every cycle.
    $display("[TB] random traffic");
    tickPeriod = 2;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 300)) idleCycle();
      applyStimulus(1'b1, 8'($urandom), tickNow());
    end
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
